// File: rtl/axil_spi_reg_pkg.sv
// -----------------------------------------------------------------------------
// axil_spi_reg_pkg
// Shared types and constants for the accel SPI AXI4-Lite register slave:
//   - DATA_W / STRB_W : fixed 32-bit data path and its byte-strobe width
//   - resp_t          : AXI response codes used on BRESP/RRESP
//   - wr_state_t      : write-channel FSM states
//   - rd_state_t      : read-channel FSM states
//   - apply_strb()    : byte-lane merge of new write data into an old word
// -----------------------------------------------------------------------------
package axil_spi_reg_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [DATA_W-1:0] apply_strb(
    input logic [DATA_W-1:0] old_v,
    input logic [DATA_W-1:0] new_v,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] res;
    res = old_v;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_spi_reg_if.sv
// -----------------------------------------------------------------------------
// axil_spi_reg_if
// AXI4-Lite bus bundle between the PS/VIP master and the SPI register slave.
// Parameter:
//   ADDR_W : byte-address width of AWADDR/ARADDR
// Channels (signal names follow the Xilinx S00_AXI naming):
//   AW : S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_AWREADY
//   W  : S_AXI_WDATA,  S_AXI_WSTRB,  S_AXI_WVALID,  S_AXI_WREADY
//   B  : S_AXI_BRESP,  S_AXI_BVALID, S_AXI_BREADY
//   AR : S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_ARREADY
//   R  : S_AXI_RDATA,  S_AXI_RRESP,  S_AXI_RVALID,  S_AXI_RREADY
// Modports: master (PS side) and slave (register bank side).
// -----------------------------------------------------------------------------
interface axil_spi_reg_if #(
  parameter int ADDR_W = 4
);
  import axil_spi_reg_pkg::*;

  logic [ADDR_W-1:0] S_AXI_AWADDR;
  logic [2:0]        S_AXI_AWPROT;
  logic              S_AXI_AWVALID;
  logic              S_AXI_AWREADY;

  logic [DATA_W-1:0] S_AXI_WDATA;
  logic [STRB_W-1:0] S_AXI_WSTRB;
  logic              S_AXI_WVALID;
  logic              S_AXI_WREADY;

  logic [1:0]        S_AXI_BRESP;
  logic              S_AXI_BVALID;
  logic              S_AXI_BREADY;

  logic [ADDR_W-1:0] S_AXI_ARADDR;
  logic [2:0]        S_AXI_ARPROT;
  logic              S_AXI_ARVALID;
  logic              S_AXI_ARREADY;

  logic [DATA_W-1:0] S_AXI_RDATA;
  logic [1:0]        S_AXI_RRESP;
  logic              S_AXI_RVALID;
  logic              S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

endinterface

// File: rtl/axil_spi_reg_file.sv
// -----------------------------------------------------------------------------
// axil_spi_reg_file
// Register array for the SPI register slave: NUM_REGS x 32-bit RW registers
// with byte-strobed write, a combinational read mux and a one-cycle write
// pulse per register.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   we        : commit a write this cycle
//   widx      : register index being written
//   wdata     : write data
//   wstrb     : byte enables (a zero strobe still pulses reg_wr)
//   ridx      : register index for the read mux
//   rdata     : current (pre-write) contents of register ridx
//   reg_q     : flattened contents, reg i at bits [32i+31:32i]
//   reg_wr    : one-hot pulse, aligned with the cycle the new value appears
// -----------------------------------------------------------------------------
module axil_spi_reg_file
  import axil_spi_reg_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int IDX_W    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [IDX_W-1:0]           widx,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [STRB_W-1:0]          wstrb,
  input  logic [IDX_W-1:0]           ridx,
  output logic [DATA_W-1:0]          rdata,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        reg_wr
);

  // Packed so the flattened output is a plain alias with reg i in lane i.
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]             reg_wr_q, reg_wr_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    regs_d   = regs_q;
    reg_wr_d = '0;
    if (we) begin
      regs_d[widx]   = apply_strb(regs_q[widx], wdata, wstrb);
      reg_wr_d[widx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples the values
    // present before the edge, independent of statement order.
    if (rst) begin
      // NOTE: this is a small, software-visible register bank, not a RAM,
      // so every entry is reset to a known value.
      regs_q   <= '0;
      reg_wr_q <= '0;
    end else begin
      regs_q   <= regs_d;
      reg_wr_q <= reg_wr_d;
    end
  end

  // Read mux sees the stored value, so a same-cycle write is not forwarded.
  assign rdata  = regs_q[ridx];
  assign reg_q  = regs_q;
  assign reg_wr = reg_wr_q;

endmodule

// File: rtl/axil_spi_reg_slave.sv
// -----------------------------------------------------------------------------
// axil_spi_reg_slave
// AXI4-Lite responder implementing the S00_AXI register bank of the accel SPI
// IP. Holds the independent write and read handshake FSMs; storage lives in
// axil_spi_reg_file.
// Parameters:
//   C_S_AXI_DATA_WIDTH : data width, must be 32
//   C_S_AXI_ADDR_WIDTH : byte-address width
//   NUM_REGS           : number of 32-bit registers, power of two, >= 2,
//                        at most 2^(C_S_AXI_ADDR_WIDTH-2)
// Ports:
//   ACLK, ARESET : clock, synchronous active-high reset
//   s_axi        : AXI4-Lite slave modport (axil_spi_reg_if)
//   reg_q        : flattened register contents, reg i at [32i+31:32i]
//   reg_wr       : one-cycle write pulse per register
// Build option:
//   AXIL_SPI_REG_DECERR_EN : indices >= NUM_REGS answer SLVERR, writes are
//   dropped and reads return 0. Without it the index wraps modulo NUM_REGS
//   and every response is OKAY.
// -----------------------------------------------------------------------------
module axil_spi_reg_slave
  import axil_spi_reg_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_REGS           = 4
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  axil_spi_reg_if.slave              s_axi,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        reg_wr
);

  localparam int ADDR_W = C_S_AXI_ADDR_WIDTH;
  localparam int IDX_W  = $clog2(NUM_REGS);

  if (C_S_AXI_DATA_WIDTH != DATA_W) begin : g_bad_data_w
    $error("axil_spi_reg_slave: only a 32-bit data width is supported");
  end
  if (NUM_REGS < 2 || (NUM_REGS & (NUM_REGS - 1)) != 0 ||
      NUM_REGS > (1 << (ADDR_W - 2))) begin : g_bad_num_regs
    $error("axil_spi_reg_slave: NUM_REGS must be a power of two in [2, 2^(ADDR_W-2)]");
  end

  // Readies stay low through reset and arm on the first cycle after it.
  logic ready_en_q, ready_en_d;

  // ---------------------------------------------------------------- write side
  wr_state_t         wr_state_q, wr_state_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  resp_t             bresp_q, bresp_d;

  logic              aw_hs, w_hs;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic              wr_err;
  logic              rf_we;

  // ----------------------------------------------------------------- read side
  rd_state_t         rd_state_q, rd_state_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  resp_t             rresp_q, rresp_d;

  logic              ar_hs;
  logic              rd_err;
  logic [DATA_W-1:0] rf_rdata;

  assign s_axi.S_AXI_AWREADY = ready_en_q && (wr_state_q == W_IDLE) && !aw_done_q;
  assign s_axi.S_AXI_WREADY  = ready_en_q && (wr_state_q == W_IDLE) && !w_done_q;
  assign s_axi.S_AXI_BVALID  = (wr_state_q == W_RESP);
  assign s_axi.S_AXI_BRESP   = bresp_q;

  assign s_axi.S_AXI_ARREADY = ready_en_q && (rd_state_q == R_IDLE);
  assign s_axi.S_AXI_RVALID  = (rd_state_q == R_DATA);
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;

  assign aw_hs = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
  assign w_hs  = s_axi.S_AXI_WVALID  && s_axi.S_AXI_WREADY;
  assign ar_hs = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;

  // A channel that already handshook uses its latched copy; otherwise the
  // live bus value, so AW and W landing on the same edge commit at once.
  assign wr_addr = aw_done_q ? awaddr_q : s_axi.S_AXI_AWADDR;
  assign wr_data = w_done_q  ? wdata_q  : s_axi.S_AXI_WDATA;
  assign wr_strb = w_done_q  ? wstrb_q  : s_axi.S_AXI_WSTRB;

`ifdef AXIL_SPI_REG_DECERR_EN
  assign wr_err = 32'(wr_addr[ADDR_W-1:2]) >= 32'(NUM_REGS);
  assign rd_err = 32'(s_axi.S_AXI_ARADDR[ADDR_W-1:2]) >= 32'(NUM_REGS);
`else
  // Upper index bits are dropped below, so the index wraps modulo NUM_REGS.
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
`endif

  // Protection bits, the byte offset and any index bits above IDX_W carry no
  // meaning for this bank.
  logic unused_bits;
  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, wr_addr,
                         s_axi.S_AXI_ARADDR};

  always_comb begin
    ready_en_d = 1'b1;

    wr_state_d = wr_state_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    rf_we      = 1'b0;

    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_done_d = 1'b1;
          awaddr_d  = s_axi.S_AXI_AWADDR;
        end
        if (w_hs) begin
          w_done_d = 1'b1;
          wdata_d  = s_axi.S_AXI_WDATA;
          wstrb_d  = s_axi.S_AXI_WSTRB;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          rf_we      = !wr_err;
          bresp_d    = wr_err ? SLVERR : OKAY;
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi.S_AXI_BREADY) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;

    case (rd_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rdata_d    = rd_err ? '0 : rf_rdata;
          rresp_d    = rd_err ? SLVERR : OKAY;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi.S_AXI_RREADY) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ready_en_q <= 1'b0;
      wr_state_q <= W_IDLE;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= OKAY;
      rd_state_q <= R_IDLE;
      rdata_q    <= '0;
      rresp_q    <= OKAY;
    end else begin
      ready_en_q <= ready_en_d;
      wr_state_q <= wr_state_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      rd_state_q <= rd_state_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  axil_spi_reg_file #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_reg_file (
    .clk    (ACLK),
    .rst    (ARESET),
    .we     (rf_we),
    .widx   (wr_addr[IDX_W+1:2]),
    .wdata  (wr_data),
    .wstrb  (wr_strb),
    .ridx   (s_axi.S_AXI_ARADDR[IDX_W+1:2]),
    .rdata  (rf_rdata),
    .reg_q  (reg_q),
    .reg_wr (reg_wr)
  );

endmodule

// File: tb/tb_axil_spi_reg_slave.sv
// -----------------------------------------------------------------------------
// tb_axil_spi_reg_slave
// Directed bench for axil_spi_reg_slave with hand-computed expected values.
// Inputs change 1 time unit after the rising edge; outputs are sampled there
// too, away from the edge. With AXIL_SPI_REG_DECERR_EN defined the address
// width becomes 5 and the out-of-range cases are exercised as well.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axil_spi_reg_slave;
  import axil_spi_reg_pkg::*;

`ifdef AXIL_SPI_REG_DECERR_EN
  localparam int ADDR_W = 5;
`else
  localparam int ADDR_W = 4;
`endif
  localparam int NREGS  = 4;
  localparam int BUDGET = 50;

  logic                    aclk;
  logic                    areset;
  logic [NREGS*DATA_W-1:0] reg_q;
  logic [NREGS-1:0]        reg_wr;

  axil_spi_reg_if #(.ADDR_W(ADDR_W)) bus ();

  axil_spi_reg_slave #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (ADDR_W),
    .NUM_REGS           (NREGS)
  ) dut (
    .ACLK   (aclk),
    .ARESET (areset),
    .s_axi  (bus.slave),
    .reg_q  (reg_q),
    .reg_wr (reg_wr)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Running record of reg_wr activity, sampled on the falling edge.
  int         pulse_total = 0;
  logic [3:0] last_pulse  = '0;
  always @(negedge aclk) begin
    if (|reg_wr) begin
      pulse_total++;
      last_pulse = reg_wr;
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit aw_ok, w_ok, aw_fire, w_fire;
    int n;
    aw_ok = 0; w_ok = 0; n = 0;
    bus.S_AXI_AWADDR  = addr[ADDR_W-1:0];
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA   = data;
    bus.S_AXI_WSTRB   = strb;
    bus.S_AXI_WVALID  = 1'b1;
    bus.S_AXI_BREADY  = 1'b1;
    while (!(aw_ok && w_ok) && n < BUDGET) begin
      aw_fire = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_fire  = bus.S_AXI_WVALID  && bus.S_AXI_WREADY;
      tick();
      if (aw_fire) begin bus.S_AXI_AWVALID = 1'b0; aw_ok = 1; end
      if (w_fire)  begin bus.S_AXI_WVALID  = 1'b0; w_ok  = 1; end
      n++;
    end
    while (!bus.S_AXI_BVALID && n < BUDGET) begin
      tick();
      n++;
    end
    check("wr_timeout", 128'(n >= BUDGET), 0);
    resp = bus.S_AXI_BRESP;
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY  = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    bit ar_fire;
    int n;
    n = 0;
    bus.S_AXI_ARADDR  = addr[ADDR_W-1:0];
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_RREADY  = 1'b1;
    ar_fire = 0;
    while (!ar_fire && n < BUDGET) begin
      ar_fire = bus.S_AXI_ARREADY;
      tick();
      n++;
    end
    bus.S_AXI_ARVALID = 1'b0;
    while (!bus.S_AXI_RVALID && n < BUDGET) begin
      tick();
      n++;
    end
    check("rd_timeout", 128'(n >= BUDGET), 0);
    data = bus.S_AXI_RDATA;
    resp = bus.S_AXI_RRESP;
    tick();
    bus.S_AXI_RREADY = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]   resp;
    logic [31:0]  data;
    logic [127:0] snap;
    int           bad;
    int           pulses;

    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;

    // ---- reset state
    areset = 1'b1;
    repeat (3) tick();
    check("rst_readies", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b000);
    check("rst_valids",  {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 2'b00);
    check("rst_reg_q",   reg_q, 0);
    check("rst_rd_resp", {bus.S_AXI_RDATA, bus.S_AXI_BRESP, bus.S_AXI_RRESP}, 0);
    check("rst_reg_wr",  reg_wr, 0);
    areset = 1'b0;
    tick();
    check("readies_after_rst", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b111);

    // ---- basic writes and read-back
    for (int i = 0; i < 4; i++) begin
      axi_write(8'(4 * i), 32'(i + 1), 4'hF, resp);
      check($sformatf("wr%0d_bresp", i), resp, 2'b00);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(8'(4 * i), data, resp);
      check($sformatf("rd%0d_data", i), data, 32'(i + 1));
      check($sformatf("rd%0d_rresp", i), resp, 2'b00);
    end
    check("reg_q_basic", reg_q, 128'h00000004_00000003_00000002_00000001);

    // ---- unaligned address truncates to reg1
    axi_read(8'h06, data, resp);
    check("rd_unaligned", data, 32'h2);

    // ---- W three cycles ahead of AW
    pulses = pulse_total;
    bus.S_AXI_WDATA = 32'hDEADBEEF; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    bus.S_AXI_BREADY = 1'b0;
    tick();
    bus.S_AXI_WVALID = 1'b0;
    bad = 0;
    repeat (2) begin
      if (bus.S_AXI_BVALID || reg_wr != 0) bad++;
      tick();
    end
    if (bus.S_AXI_BVALID) bad++;
    check("w_first_no_bvalid", bad, 0);
    bus.S_AXI_AWADDR = 'h4; bus.S_AXI_AWVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    check("w_first_bvalid", bus.S_AXI_BVALID, 1'b1);
    check("w_first_reg1", reg_q[63:32], 32'hDEADBEEF);
    check("w_first_reg_wr", reg_wr, 4'b0010);
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
    tick();
    check("w_first_pulse_len", pulse_total - pulses, 1);

    // ---- byte strobes
    axi_write(8'h08, 32'hFFFFFFFF, 4'hF, resp);
    axi_write(8'h08, 32'h12345678, 4'b0101, resp);
    check("strb_reg2", reg_q[95:64], 32'hFF34FF78);

    // ---- zero strobe: no data change, pulse still fires
    pulses = pulse_total;
    axi_write(8'h0C, 32'hFFFF0000, 4'h0, resp);
    check("strb0_reg3", reg_q[127:96], 32'h4);
    check("strb0_pulses", pulse_total - pulses, 1);
    check("strb0_which", last_pulse, 4'b1000);

    // ---- B stalled ~10 cycles, R stalled 7 cycles, concurrent traffic
    bus.S_AXI_AWADDR = 'hC; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA = 32'h55AA55AA; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    bus.S_AXI_ARADDR = 'h4; bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
    tick();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    bad = 0;
    for (int c = 0; c < 7; c++) begin
      if (!(bus.S_AXI_BVALID && bus.S_AXI_RVALID && bus.S_AXI_RDATA == 32'hDEADBEEF &&
            bus.S_AXI_RRESP == 2'b00 && bus.S_AXI_BRESP == 2'b00)) bad++;
      tick();
    end
    check("stall_hold", bad, 0);
    bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_RREADY = 1'b0;
    check("r_done_b_stalled", {bus.S_AXI_RVALID, bus.S_AXI_BVALID}, 2'b01);
    axi_read(8'h0C, data, resp);
    check("rd_during_b_stall", data, 32'h55AA55AA);
    tick();
    check("b_still_held", {bus.S_AXI_BVALID, bus.S_AXI_BRESP}, 3'b100);
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
    check("b_released", bus.S_AXI_BVALID, 1'b0);

    // ---- same-cycle write and read of reg0
    bus.S_AXI_AWADDR = 'h0; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA = 32'hA5A5A5A5; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    bus.S_AXI_ARADDR = 'h0; bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    check("same_cycle_rdata", {bus.S_AXI_RVALID, bus.S_AXI_RDATA}, {1'b1, 32'h1});
    check("same_cycle_reg0", reg_q[31:0], 32'hA5A5A5A5);
    tick();
    bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
    axi_read(8'h00, data, resp);
    check("same_cycle_readback", data, 32'hA5A5A5A5);

    // ---- reset with B and R pending
    bus.S_AXI_AWADDR = 'h8; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA = 32'h11112222; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    bus.S_AXI_ARADDR = 'h8; bus.S_AXI_ARVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    check("pending_before_rst", {bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_RDATA},
          {2'b11, 32'hFF34FF78});
    areset = 1'b1;
    tick();
    check("mid_rst_valids", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 2'b00);
    check("mid_rst_regs", reg_q, 0);
    check("mid_rst_rdata", bus.S_AXI_RDATA, 0);
    areset = 1'b0;
    tick();
    check("mid_rst_rearm", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b111);

    // ---- a W latched before reset must be discarded
    bus.S_AXI_WDATA = 32'hBAD0BAD0; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    tick();
    bus.S_AXI_WVALID = 1'b0;
    areset = 1'b1;
    tick();
    areset = 1'b0;
    tick();
    bus.S_AXI_AWADDR = 'h8; bus.S_AXI_AWVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    bad = 0;
    repeat (3) begin
      if (bus.S_AXI_BVALID) bad++;
      tick();
    end
    check("stale_w_discarded", bad, 0);
    bus.S_AXI_WDATA = 32'h600D600D; bus.S_AXI_WVALID = 1'b1;
    tick();
    bus.S_AXI_WVALID = 1'b0;
    check("post_rst_wr", {bus.S_AXI_BVALID, reg_q[95:64]}, {1'b1, 32'h600D600D});
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
    axi_read(8'h08, data, resp);
    check("post_rst_rd", {resp, data}, {2'b00, 32'h600D600D});

`ifdef AXIL_SPI_REG_DECERR_EN
    // ---- out-of-range index
    snap   = reg_q;
    pulses = pulse_total;
    axi_write(8'h10, 32'hCAFEF00D, 4'hF, resp);
    check("decerr_bresp", resp, 2'b10);
    check("decerr_regs_kept", reg_q, snap);
    check("decerr_no_pulse", pulse_total - pulses, 0);
    axi_read(8'h14, data, resp);
    check("decerr_rd", {resp, data}, {2'b10, 32'h0});
`else
    snap = reg_q;
    check("final_reg_q", snap, 128'h00000000_600D600D_00000000_00000000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
